i2c_target: RTL and testbench

- I2C target (responder) that exposes a 16-byte register file to an external I2C controller, for example a ground-link MCU reading telemetry.
- The CPU fills and reads the register file through the usual WE/DATA_IN/DATA_OUT peripheral port on the bus controller.
- SCL and SDA are oversampled on CLK (CLK_CPU). The block never stretches SCL.
- The top level builds the open-drain pad: SDA = SDA_OE ? 0 : 'z'.

---
 rtl/i2c_target.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target exposing a 2^NREGS_LOG2-byte register file to an external controller.
// SCL/SDA are oversampled on CLK; SCL is never stretched.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR   = 7'h42,
  parameter int unsigned NREGS_LOG2 = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WE,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  output logic        SDA_OE
);
  localparam int unsigned PW    = NREGS_LOG2;
  localparam int unsigned NREGS = 1 << NREGS_LOG2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_PTR, ST_ACK_P,
    ST_WR, ST_ACK_W, ST_RD, ST_MACK, ST_IGNORE
  } state_e;

  logic          scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic          sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          phase_q, phase_d;
  logic          rw_q, rw_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];
  logic [PW-1:0] last_idx_q, last_idx_d;
  logic [7:0]    last_byte_q, last_byte_d;
  logic          new_wr_q, new_wr_d;
  logic          sda_oe_q, sda_oe_d;
  logic [31:0]   data_out_q, data_out_d;

  logic          scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [7:0]    byte_c;
  logic          unused_c;

  assign scl_rise_c = scl_s2_q & ~scl_h_q;
  assign scl_fall_c = ~scl_s2_q & scl_h_q;
  assign start_c    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_c     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign byte_c     = {shift_q[6:0], sda_s2_q};
  assign unused_c   = ^{DATA_IN[31:8+PW], shift_q[7]};

  assign DATA_OUT = data_out_q;
  assign SDA_OE   = sda_oe_q;

  // Next-state, datapath and register-file update.
  always_comb begin
    scl_s1_d    = SCL_IN;
    scl_s2_d    = scl_s1_q;
    scl_h_d     = scl_s2_q;
    sda_s1_d    = SDA_IN;
    sda_s2_d    = sda_s1_q;
    sda_h_d     = sda_s2_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    last_idx_d  = last_idx_q;
    last_byte_d = last_byte_q;
    new_wr_d    = new_wr_q;
    sda_oe_d    = sda_oe_q;
    data_out_d  = {14'b0, (state_q != ST_IDLE), new_wr_q, 4'b0, 4'(last_idx_q), last_byte_q};

    // CPU write first so a same-cycle bus write below overrides it.
    if (WE) begin
      regs_d[DATA_IN[8 +: PW]] = DATA_IN[7:0];
      new_wr_d                 = 1'b0;
    end

    if (start_c) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise_c) begin
            shift_d   = byte_c;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b0;
              if (state_q == ST_ADDR) begin
                if (byte_c[7:1] == DEV_ADDR) begin
                  rw_d    = byte_c[0];
                  state_d = ST_ACK_A;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = byte_c[PW-1:0];
                state_d = ST_ACK_P;
              end else begin
                regs_d[ptr_q] = byte_c;
                last_idx_d    = ptr_q;
                last_byte_d   = byte_c;
                new_wr_d      = 1'b1;
                ptr_d         = ptr_q + 1'b1;
                state_d       = ST_ACK_W;
              end
            end
          end
        end
        // phase 0: waiting for the fall ending bit 8; phase 1: driving ACK.
        ST_ACK_A, ST_ACK_P, ST_ACK_W: begin
          if (scl_fall_c) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ST_ACK_A && rw_q) begin
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
                ptr_d    = ptr_q + 1'b1;
                state_d  = ST_RD;
              end else if (state_q == ST_ACK_A) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WR;
              end
            end
          end
        end
        ST_RD: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_MACK;
              phase_d = 1'b0;
            end
          end else if (scl_fall_c) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        ST_MACK: begin
          if (scl_fall_c && !phase_q) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b1;
          end else if (scl_rise_c && phase_q) begin
            if (sda_s2_q) state_d = ST_IGNORE;
          end else if (scl_fall_c && phase_q) begin
            shift_d   = regs_q[ptr_q];
            sda_oe_d  = ~regs_q[ptr_q][7];
            ptr_d     = ptr_q + 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = ST_RD;
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_h_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_h_q     <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      phase_q     <= 1'b0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
      last_idx_q  <= '0;
      last_byte_q <= 8'd0;
      new_wr_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      data_out_q  <= 32'd0;
    end else begin
      scl_s1_q    <= scl_s1_d;
      scl_s2_q    <= scl_s2_d;
      scl_h_q     <= scl_h_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
      sda_h_q     <= sda_h_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      regs_q      <= regs_d;
      last_idx_q  <= last_idx_d;
      last_byte_q <= last_byte_d;
      new_wr_q    <= new_wr_d;
      sda_oe_q    <= sda_oe_d;
      data_out_q  <= data_out_d;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: an I2C controller model on a wired-AND SDA line, checked
// against a transaction-level register-file model.
module tb_i2c_target;
  localparam int Q = 8;  // quarter SCL period in CLK cycles

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        m_scl;
  logic        m_sda;
  logic        sda_oe;
  logic        sda_in;

  int checks = 0;
  int errors = 0;
  int oe_seen = 0;

  logic [7:0] m_regs [16];
  logic [3:0] m_ptr;
  logic [3:0] m_last_idx;
  logic [7:0] m_last_byte;
  logic       m_new_wr;
  logic       m_busy;
  logic [7:0] wbuf [8];

  assign sda_in = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  always @(posedge clk) if (sda_oe === 1'b1) oe_seen <= oe_seen + 1;

  i2c_target #(.DEV_ADDR(7'h42), .NREGS_LOG2(4)) dut (
    .CLK(clk), .RESET(reset_n), .WE(we), .DATA_IN(data_in), .DATA_OUT(data_out),
    .SCL_IN(m_scl), .SDA_IN(sda_in), .SDA_OE(sda_oe)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_dout();
    return {14'b0, m_busy, m_new_wr, 4'b0, m_last_idx, m_last_byte};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 4'd0; m_last_idx = 4'd0; m_last_byte = 8'h00; m_new_wr = 1'b0; m_busy = 1'b0;
  endtask

  task automatic cpu_write(input logic [3:0] idx, input logic [7:0] b);
    we = 1'b1;
    data_in = {20'($urandom), idx, b};
    wait_clks(1);
    we = 1'b0;
    m_regs[idx] = b;
    m_new_wr = 1'b0;
    wait_clks(2);
  endtask

  task automatic clk_bit(input logic v, output logic s);
    m_sda = v;  wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    s = sda_in; wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic do_start();
    m_sda = 1'b1; m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
    m_busy = 1'b1;
  endtask

  task automatic do_rstart();
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b1; wait_clks(2 * Q);
    m_busy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    m_sda = nack; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    check("mack_sda_oe", 32'(sda_oe), 32'(0));
    wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  // Bus write: pointer byte p followed by wbuf[0..n-1].
  task automatic mwrite(input logic [7:0] p, input int n);
    logic ack;
    do_start();
    send_byte(8'h84, ack); check("wr_addr_ack", 32'(ack), 32'(0));
    send_byte(p, ack);     check("wr_ptr_ack", 32'(ack), 32'(0));
    m_ptr = p[3:0];
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      check("wr_data_ack", 32'(ack), 32'(0));
      m_regs[m_ptr] = wbuf[i];
      m_last_idx = m_ptr; m_last_byte = wbuf[i]; m_new_wr = 1'b1;
      m_ptr = m_ptr + 4'd1;
    end
    wait_clks(4);
    check("wr_dout_busy", data_out, exp_dout());
    do_stop();
    check("wr_dout_idle", data_out, exp_dout());
  endtask

  // Bus read of n bytes, optionally setting the pointer first via a repeated START.
  task automatic mread(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    do_start();
    if (set_ptr) begin
      send_byte(8'h84, ack); check("rd_waddr_ack", 32'(ack), 32'(0));
      send_byte(p, ack);     check("rd_ptr_ack", 32'(ack), 32'(0));
      m_ptr = p[3:0];
      do_rstart();
    end
    send_byte(8'h85, ack); check("rd_addr_ack", 32'(ack), 32'(0));
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      check("rd_byte", 32'(b), 32'(m_regs[m_ptr]));
      m_ptr = m_ptr + 4'd1;
    end
    do_stop();
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] b;
    logic [7:0] p;
    int         n;
    int         oe0;

    reset_n = 1'b0; we = 1'b0; data_in = 32'h0; m_scl = 1'b1; m_sda = 1'b1;
    model_reset();
    wait_clks(5);
    reset_n = 1'b1;
    wait_clks(3);
    check("reset_dout", data_out, 32'h0);
    check("reset_sda_oe", 32'(sda_oe), 32'(0));

    // Write burst, then CPU write clears NEW_WR.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    mwrite(8'h05, 2);
    check("burst_new_wr", 32'(data_out[16]), 32'(1));
    cpu_write(4'h9, 8'h00);
    check("cpu_clears_new_wr", data_out, exp_dout());
    mread(1'b1, 8'h05, 2);

    // Read with repeated START, then confirm the pointer moved past both bytes.
    cpu_write(4'h3, 8'h3C);
    cpu_write(4'h4, 8'hC3);
    mread(1'b1, 8'h03, 2);
    check("rd_ptr_after", 32'(m_ptr), 32'(5));
    mread(1'b0, 8'h00, 1);

    // Address mismatch: never acknowledged, SDA never pulled.
    oe0 = oe_seen;
    do_start();
    send_byte(8'h90, ack); check("nomatch_addr_nack", 32'(ack), 32'(1));
    send_byte(8'h00, ack); check("nomatch_data_nack", 32'(ack), 32'(1));
    do_stop();
    check("nomatch_sda_oe", 32'(oe_seen - oe0), 32'(0));
    check("nomatch_dout", data_out, exp_dout());

    // Pointer wrap-around.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    mwrite(8'hFF, 2);
    mread(1'b1, 8'h0F, 2);

    // STOP after four data bits: nothing written.
    do_start();
    send_byte(8'h84, ack); check("abort_addr_ack", 32'(ack), 32'(0));
    send_byte(8'h07, ack); check("abort_ptr_ack", 32'(ack), 32'(0));
    m_ptr = 4'd7;
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    do_stop();
    check("abort_dout", data_out, exp_dout());
    mread(1'b1, 8'h07, 1);

    // CPU WE and bus write hit reg2 on the same CLK edge; bus data must win.
    do_start();
    send_byte(8'h84, ack); check("coll_addr_ack", 32'(ack), 32'(0));
    send_byte(8'h02, ack); check("coll_ptr_ack", 32'(ack), 32'(0));
    b = 8'h77;
    for (int i = 7; i >= 1; i--) clk_bit(b[i], s);
    m_sda = b[0]; wait_clks(Q);
    m_scl = 1'b1; wait_clks(2);
    we = 1'b1; data_in = {20'h0, 4'h2, 8'h99};
    wait_clks(1);
    we = 1'b0;
    wait_clks(2 * Q - 3);
    m_scl = 1'b0; wait_clks(Q);
    clk_bit(1'b1, ack); check("coll_data_ack", 32'(ack), 32'(0));
    m_regs[2] = 8'h77; m_last_idx = 4'd2; m_last_byte = 8'h77; m_new_wr = 1'b1; m_ptr = 4'd3;
    do_stop();
    check("coll_dout", data_out, exp_dout());
    mread(1'b1, 8'h02, 1);

    // Randomized write bursts with read-back one byte past the written range.
    for (int it = 0; it < 5; it++) begin
      p = 8'($urandom);
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
      mwrite(p, n);
      if ($urandom_range(0, 1) == 1) cpu_write(4'($urandom), 8'($urandom));
      mread(1'b1, p, n + 1);
    end

    // Reset while the target is driving an address ACK.
    do_start();
    for (int i = 7; i >= 0; i--) clk_bit(((8'h84 >> i) & 8'h01) != 8'h00, s);
    check("ack_sda_oe_high", 32'(sda_oe), 32'(1));
    reset_n = 1'b0;
    wait_clks(1);
    check("rst_mid_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_mid_dout", data_out, 32'h0);
    reset_n = 1'b1;
    model_reset();
    do_stop();
    cpu_write(4'h0, 8'h5C);
    mread(1'b0, 8'h00, 1);
    mread(1'b1, 8'h06, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
